// File: rtl/fft_pkg.sv
// Shared types and sizes for the FFT datapath serial/parallel stages.
// Contents: frame geometry, sample/frame/index typedefs, PTS state encoding.
package fft_pkg;

    localparam int N_SAMPLES = 48;
    localparam int DATA_W    = 16;
    localparam int IDX_W     = $clog2(N_SAMPLES);

    typedef logic [DATA_W-1:0]      sample_t;
    typedef sample_t [N_SAMPLES-1:0] frame_t;
    typedef logic [IDX_W-1:0]       idx_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } pts_state_t;

    localparam idx_t LAST_IDX = idx_t'(N_SAMPLES - 1);

endpackage

// File: rtl/pts_wrapper_if.sv
// Serial sample stream between pts_wrapper and the result consumer.
// Signals: out_data/out_valid/out_last (source->sink), out_ready (sink->source).
interface pts_wrapper_if;
    import fft_pkg::*;

    sample_t out_data;
    logic    out_valid;
    logic    out_ready;
    logic    out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/pts_frame_buf.sv
// One registered frame of samples with a whole-frame write and indexed read.
// Ports: clk, we (write enable), wdata (frame), ridx (sample index), rdata.
module pts_frame_buf
    import fft_pkg::*;
(
    input  logic    clk,
    input  logic    we,
    input  frame_t  wdata,
    input  idx_t    ridx,
    output sample_t rdata
);

    frame_t mem;

    // Contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (we) begin
            mem <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/pts_wrapper.sv
// Parallel-to-serial output stage: captures a 48-sample frame, streams it out.
// Ports: clk, rst (sync, active-high), load/data_par/load_ready (frame capture),
//   out_if (serial stream master), frame_done (pulse), overflow (sticky).
// Option: PTS_DOUBLE_BUF_EN adds a shadow frame so frames stream back-to-back.
module pts_wrapper
    import fft_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  frame_t data_par,
    output logic   load_ready,
    output logic   frame_done,
    output logic   overflow,
    pts_wrapper_if.master out_if
);

    localparam logic [0:0] ST_IDLE  = 1'(IDLE);
    localparam logic [0:0] ST_DRAIN = 1'(DRAIN);

    logic [0:0] state;
    idx_t       idx;
    logic       drain;
    logic       beat;
    logic       last_beat;
    logic       load_acc;
    logic       cont;
    sample_t    sample;

    assign drain     = (state == ST_DRAIN);
    assign beat      = drain && out_if.out_ready;
    assign last_beat = beat && (idx == LAST_IDX);
    assign load_acc  = load && load_ready;

`ifdef PTS_DOUBLE_BUF_EN
    // Two physical buffers in ping-pong: "act" is the one being drained,
    // the other is the shadow. Moving the shadow into the main buffer is
    // done by flipping act, which gives the same stream with no copy.
    logic    act;
    logic    shadow_full;
    logic    wsel;
    logic    we0;
    logic    we1;
    sample_t rd0;
    sample_t rd1;

    assign load_ready = !drain || !shadow_full;
    assign wsel       = drain ? !act : act;
    assign we0        = load_acc && !wsel;
    assign we1        = load_acc &&  wsel;
    // A load landing on the last beat fills the shadow and is taken at once.
    assign cont       = last_beat && (shadow_full || load_acc);
    assign sample     = act ? rd1 : rd0;

    pts_frame_buf u_buf0 (
        .clk   (clk),
        .we    (we0),
        .wdata (data_par),
        .ridx  (idx),
        .rdata (rd0)
    );

    pts_frame_buf u_buf1 (
        .clk   (clk),
        .we    (we1),
        .wdata (data_par),
        .ridx  (idx),
        .rdata (rd1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            act         <= 1'b0;
            shadow_full <= 1'b0;
        end else if (cont) begin
            act         <= !act;
            shadow_full <= 1'b0;
        end else if (load_acc && drain) begin
            shadow_full <= 1'b1;
        end
    end
`else
    assign load_ready = !drain;
    assign cont       = 1'b0;

    pts_frame_buf u_buf0 (
        .clk   (clk),
        .we    (load_acc),
        .wdata (data_par),
        .ridx  (idx),
        .rdata (sample)
    );
`endif

    assign out_if.out_valid = drain;
    assign out_if.out_last  = drain && (idx == LAST_IDX);
    // Buffer is don't-care outside DRAIN; present zero instead.
    assign out_if.out_data  = drain ? sample : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= last_beat;
            if (load && !load_ready) begin
                overflow <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (load_acc) begin
                        state <= ST_DRAIN;
                        idx   <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (last_beat) begin
                        idx   <= '0;
                        state <= cont ? ST_DRAIN : ST_IDLE;
                    end else if (beat) begin
                        idx <= idx + idx_t'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pts_wrapper.sv
// Directed self-checking bench for pts_wrapper.
// Covers reset/idle, full frame, backpressure, overflow, mid-frame reset.
module tb_pts_wrapper;
    import fft_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    logic   load;
    frame_t data_par;
    logic   load_ready;
    logic   frame_done;
    logic   overflow;

    int checks = 0;
    int errors = 0;

    pts_wrapper_if sif ();

    pts_wrapper dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_par   (data_par),
        .load_ready (load_ready),
        .frame_done (frame_done),
        .overflow   (overflow),
        .out_if     (sif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [15:0] base, input bit down);
        for (int i = 0; i < N_SAMPLES; i++) begin
            data_par[i] = down ? base - 16'(i) : base + 16'(i);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_load();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        logic [3:0] pat;
        int e;
        int k;

        rst = 1'b1;
        load = 1'b0;
        data_par = '0;
        sif.out_ready = 1'b0;
        pat = 4'b1001;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_valid", sif.out_valid, 0);
        chk("rst_data", sif.out_data, 0);
        chk("rst_last", sif.out_last, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_lready", load_ready, 1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_lready", load_ready, 1);
            chk("idle_valid", sif.out_valid, 0);
        end

        // Single frame, out_ready held high
        sif.out_ready = 1'b1;
        fill(16'h0000, 1'b0);
        do_load();
        for (int i = 0; i < N_SAMPLES; i++) begin
            chk("sf_valid", sif.out_valid, 1);
            chk("sf_data", sif.out_data, 32'(i));
            chk("sf_last", sif.out_last, 32'(i == 47));
            chk("sf_done_early", frame_done, 0);
            chk("sf_lready", load_ready, 0);
            @(negedge clk);
        end
        chk("sf_done", frame_done, 1);
        chk("sf_valid_end", sif.out_valid, 0);
        chk("sf_lready_end", load_ready, 1);
        @(negedge clk);
        chk("sf_done_pulse", frame_done, 0);

        // Backpressure: ready pattern 1,0,0,1
        fill(16'hA000, 1'b0);
        do_load();
        e = 0;
        k = 0;
        while (e < N_SAMPLES && k < 400) begin
            chk("bp_valid", sif.out_valid, 1);
            chk("bp_data", sif.out_data, 32'(16'hA000 + 16'(e)));
            chk("bp_last", sif.out_last, 32'(e == 47));
            sif.out_ready = pat[k % 4];
            @(negedge clk);
            if (sif.out_ready) e++;
            k++;
        end
        chk("bp_count", 32'(e), 48);
        chk("bp_done", frame_done, 1);
        sif.out_ready = 1'b1;
        @(negedge clk);

`ifndef PTS_DOUBLE_BUF_EN
        // Overflow: load during drain is dropped
        fill(16'h5000, 1'b0);
        do_load();
        for (int i = 0; i < N_SAMPLES; i++) begin
            chk("ov_data", sif.out_data, 32'(16'h5000 + 16'(i)));
            chk("ov_flag", overflow, 32'(i > 10));
            if (i == 10) begin
                for (int j = 0; j < N_SAMPLES; j++) data_par[j] = 16'hDEAD;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        chk("ov_done", frame_done, 1);
        repeat (5) @(negedge clk);
        chk("ov_sticky", overflow, 1);
`else
        // Double buffer: A then B loaded at beat 5, 96 back-to-back beats
        fill(16'h1000, 1'b0);
        do_load();
        for (int s = 0; s < 2 * N_SAMPLES; s++) begin
            chk("db_valid", sif.out_valid, 1);
            chk("db_data", sif.out_data, (s < 48) ?
                32'(16'h1000 + 16'(s)) : 32'(16'h2000 + 16'(s - 48)));
            chk("db_done", frame_done, 32'(s == 48));
            chk("db_ovf", overflow, 0);
            if (s == 5) begin
                fill(16'h2000, 1'b0);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        chk("db_done_end", frame_done, 1);
        chk("db_valid_end", sif.out_valid, 0);
        @(negedge clk);
`endif

        // Reset mid-frame then restart
        fill(16'h3000, 1'b0);
        do_load();
        for (int i = 0; i <= 20; i++) begin
            chk("rm_data", sif.out_data, 32'(16'h3000 + 16'(i)));
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rm_valid", sif.out_valid, 0);
        chk("rm_data0", sif.out_data, 0);
        chk("rm_ovf", overflow, 0);
        chk("rm_lready", load_ready, 1);
        rst = 1'b0;
        fill(16'hFFFF, 1'b1);
        do_load();
        for (int i = 0; i < N_SAMPLES; i++) begin
            chk("rs_data", sif.out_data, 32'(16'hFFFF - 16'(i)));
            chk("rs_last", sif.out_last, 32'(i == 47));
            @(negedge clk);
        end
        chk("rs_done", frame_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
